// File: rtl/cpu_pkg.sv
// Shared opcode constants, the NOP instruction word and the pipeline state enum
// for the four-stage instruction-register pipeline.
package cpu_pkg;

    localparam logic [3:0] LOAD  = 4'b0000;
    localparam logic [3:0] STOP  = 4'b0001;
    localparam logic [3:0] STORE = 4'b0100;
    localparam logic [3:0] NOP   = 4'b1010;
    localparam logic [3:0] BPZ   = 4'b1101;
    localparam logic [3:0] BZ    = 4'b0101;
    localparam logic [3:0] BNZ   = 4'b1001;

    localparam logic [7:0] NOP_INSTR = 8'h0A;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/ir_pipeline_if.sv
// Bundle of fetch-side inputs and IR/status outputs of ir_pipeline.
// Optional BubbleCount exists only when IR_PIPE_PERF_EN is defined.
interface ir_pipeline_if;
    import cpu_pkg::*;

    // FetchValid qualifies IMemOut in the same cycle; there is no back-pressure
    // wire, PCWrite=1 tells the fetch side the offered word was consumed.
    logic [7:0] IMemOut;
    logic       FetchValid;
    logic       BranchTaken;
    logic       Hold;
    logic [7:0] IR1Out;
    logic [7:0] IR2Out;
    logic [7:0] IR3Out;
    logic [7:0] IR4Out;
    logic       PCWrite;
    logic       Halted;
    state_e     dbg_state;
`ifdef IR_PIPE_PERF_EN
    logic [15:0] BubbleCount;
`endif

    modport master (
        output IMemOut, FetchValid, BranchTaken, Hold,
        input  IR1Out, IR2Out, IR3Out, IR4Out, PCWrite, Halted, dbg_state
`ifdef IR_PIPE_PERF_EN
        , input BubbleCount
`endif
    );

    modport slave (
        input  IMemOut, FetchValid, BranchTaken, Hold,
        output IR1Out, IR2Out, IR3Out, IR4Out, PCWrite, Halted, dbg_state
`ifdef IR_PIPE_PERF_EN
        , output BubbleCount
`endif
    );

endinterface

// File: rtl/ir_hazard_detect.sv
// Combinational load-use detector: a load in IR2 whose destination register is
// read as either source field of the instruction in IR1.
module ir_hazard_detect
    import cpu_pkg::*;
(
    input  logic [3:0] i_ir1_srcs,
    input  logic [3:0] i_ir2_op,
    input  logic [1:0] i_ir2_dest,
    output logic       o_hazard
);

    logic w_is_load;
    logic w_src_match;

    assign w_is_load   = (i_ir2_op == LOAD);
    assign w_src_match = (i_ir1_srcs[3:2] == i_ir2_dest) ||
                         (i_ir1_srcs[1:0] == i_ir2_dest);
    assign o_hazard    = w_is_load && w_src_match;

endmodule

// File: rtl/ir_pipeline.sv
// Four-stage instruction-register pipeline with load-use stall, branch flush,
// global hold and stop/halt handling. Define IR_PIPE_PERF_EN to add BubbleCount.
module ir_pipeline
    import cpu_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    ir_pipeline_if.slave bus
);

    logic [7:0] r_ir1;
    logic [7:0] r_ir2;
    logic [7:0] r_ir3;
    logic [7:0] r_ir4;
    state_e     r_state;
    logic       r_stop_pend;

    state_e     w_next_state;
    logic       w_hazard;
    logic       w_load_use;
    logic       w_stop_ir4;
    logic       w_halt;
    logic [7:0] w_fetch;
    logic       w_pc_write;

    ir_hazard_detect u_hazard (
        .i_ir1_srcs (r_ir1[7:4]),
        .i_ir2_op   (r_ir2[3:0]),
        .i_ir2_dest (r_ir2[7:6]),
        .o_hazard   (w_hazard)
    );

    // A stop sitting in IR4 freezes the pipe on the same edge it enters HALT.
    assign w_stop_ir4 = (r_ir4[3:0] == STOP);
    assign w_halt     = (r_state == HALT) || w_stop_ir4;
    assign w_load_use = w_hazard && (r_state != FLUSH);

    // Once a stop has been fetched nothing after it may enter the pipe.
    assign w_fetch = (r_stop_pend || !bus.FetchValid) ? NOP_INSTR : bus.IMemOut;

    always_comb begin
        w_next_state = RUN;
        if (w_halt)
            w_next_state = HALT;
        else if (bus.BranchTaken)
            w_next_state = FLUSH;
        else if (bus.Hold)
            w_next_state = r_state;
        else if (w_load_use)
            w_next_state = STALL;
    end

    always_comb begin
        w_pc_write = 1'b1;
        if (w_halt)
            w_pc_write = 1'b0;
        else if (bus.BranchTaken)
            w_pc_write = 1'b1;
        else if (r_stop_pend || bus.Hold || w_load_use)
            w_pc_write = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ir1       <= NOP_INSTR;
            r_ir2       <= NOP_INSTR;
            r_ir3       <= NOP_INSTR;
            r_ir4       <= NOP_INSTR;
            r_state     <= RUN;
            r_stop_pend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_halt) begin
                r_ir1 <= r_ir1;
            end else if (bus.BranchTaken) begin
                // A stop squashed out of IR1 must not keep the PC frozen.
                r_ir1       <= NOP_INSTR;
                r_ir2       <= NOP_INSTR;
                r_ir3       <= r_ir2;
                r_ir4       <= r_ir3;
                r_stop_pend <= r_stop_pend && (r_ir1[3:0] != STOP);
            end else if (bus.Hold) begin
                r_ir1 <= r_ir1;
            end else if (w_load_use) begin
                r_ir2 <= NOP_INSTR;
                r_ir3 <= r_ir2;
                r_ir4 <= r_ir3;
            end else begin
                r_ir1 <= w_fetch;
                r_ir2 <= r_ir1;
                r_ir3 <= r_ir2;
                r_ir4 <= r_ir3;
                if (w_fetch[3:0] == STOP)
                    r_stop_pend <= 1'b1;
            end
        end
    end

`ifdef IR_PIPE_PERF_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_bubble_cnt <= 16'd0;
        else if (((r_state == STALL) || (r_state == FLUSH)) && (r_bubble_cnt != 16'hFFFF))
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end

    assign bus.BubbleCount = r_bubble_cnt;
`endif

    assign bus.IR1Out    = r_ir1;
    assign bus.IR2Out    = r_ir2;
    assign bus.IR3Out    = r_ir3;
    assign bus.IR4Out    = r_ir4;
    assign bus.PCWrite   = w_pc_write;
    assign bus.Halted    = (r_state == HALT);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ir_pipeline.sv
// Self-checking bench for ir_pipeline: per-scenario tasks push expected
// {state, Halted, IR1..IR4} snapshots to a queue and compare after each edge.
module tb_ir_pipeline;
    import cpu_pkg::*;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;
    localparam logic [7:0] N       = 8'h0A;

    logic clock;
    logic reset;
    int   checks;
    int   passed;
    logic [34:0] exp_q[$];

    ir_pipeline_if bus ();

    ir_pipeline u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [34:0] mk(input logic [1:0] st, input logic h,
                                       input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {st, h, a, b, c, d};
    endfunction

    function automatic logic [34:0] snap();
        return {bus.dbg_state, bus.Halted, bus.IR1Out, bus.IR2Out, bus.IR3Out, bus.IR4Out};
    endfunction

    task automatic cycle(input logic [7:0] imem, input logic fv, input logic br, input logic hd);
        @(negedge clock);
        bus.IMemOut     = imem;
        bus.FetchValid  = fv;
        bus.BranchTaken = br;
        bus.Hold        = hd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(8'h00, 1'b0, 1'b0, 1'b0);
            @(posedge clock);
        end
    endtask

    task automatic test_reset();
        logic [34:0] got;
        bus.IMemOut = 8'h00; bus.FetchValid = 1'b0; bus.BranchTaken = 1'b0; bus.Hold = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        got = snap();
        checks++; if (got !== mk(S_RUN, 1'b0, N, N, N, N)) $display("FAIL reset_state: got %h want %h", got, mk(S_RUN, 1'b0, N, N, N, N)); else passed++;
`ifdef IR_PIPE_PERF_EN
        checks++; if (bus.BubbleCount !== 16'd0) $display("FAIL reset_bubbles: got %0d want 0", bus.BubbleCount); else passed++;
`endif
        @(negedge clock); reset = 1'b1; #2;
        checks++; if (bus.PCWrite !== 1'b1) $display("FAIL reset_pcwrite: got %b want 1", bus.PCWrite); else passed++;
    endtask

    task automatic test_straight();
        logic [7:0]  in_t [8];
        logic [34:0] ex_t [8];
        logic [7:0]  fv_v;
        logic [34:0] got, ex;
        in_t = '{8'h14, 8'h24, 8'h34, 8'h44, N, N, N, N};
        fv_v = 8'b0000_1111;
        ex_t = '{mk(S_RUN, 0, 8'h14, N, N, N), mk(S_RUN, 0, 8'h24, 8'h14, N, N),
                 mk(S_RUN, 0, 8'h34, 8'h24, 8'h14, N), mk(S_RUN, 0, 8'h44, 8'h34, 8'h24, 8'h14),
                 mk(S_RUN, 0, N, 8'h44, 8'h34, 8'h24), mk(S_RUN, 0, N, N, 8'h44, 8'h34),
                 mk(S_RUN, 0, N, N, N, 8'h44), mk(S_RUN, 0, N, N, N, N)};
        for (int i = 0; i < 8; i++) begin
            cycle(in_t[i], fv_v[i], 1'b0, 1'b0);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== 1'b1) $display("FAIL straight_pcwrite[%0d]: got %b want 1", i, bus.PCWrite); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL straight_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
    endtask

    task automatic test_load_use(input logic [7:0] ld, input logic [7:0] user, input logic hz);
        logic [34:0] ex_t [4];
        logic [3:0]  pc_v;
        logic [34:0] got, ex;
        pc_v = hz ? 4'b1011 : 4'b1111;
        ex_t = '{mk(S_RUN, 0, ld, N, N, N), mk(S_RUN, 0, user, ld, N, N),
                 hz ? mk(S_STALL, 0, user, N, ld, N) : mk(S_RUN, 0, N, user, ld, N),
                 hz ? mk(S_RUN, 0, N, user, N, ld)   : mk(S_RUN, 0, N, N, user, ld)};
        for (int i = 0; i < 4; i++) begin
            cycle((i == 0) ? ld : user, (i < 2), 1'b0, 1'b0);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== pc_v[i]) $display("FAIL load_use_pcwrite[%h/%h:%0d]: got %b want %b", ld, user, i, bus.PCWrite, pc_v[i]); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL load_use_state[%h/%h:%0d]: got %h want %h", ld, user, i, got, ex); else passed++;
        end
        idle(4); #1;
        got = snap();
        checks++; if (got !== mk(S_RUN, 0, N, N, N, N)) $display("FAIL load_use_drain: got %h want %h", got, mk(S_RUN, 0, N, N, N, N)); else passed++;
    endtask

    task automatic test_branch();
        logic [7:0]  in_t [7];
        logic [34:0] ex_t [7];
        logic [6:0]  fv_v, br_v;
        logic [34:0] got, ex;
        in_t = '{8'h34, 8'h24, 8'h44, 8'h54, N, N, N};
        fv_v = 7'b000_1111;
        br_v = 7'b000_0100;
        ex_t = '{mk(S_RUN, 0, 8'h34, N, N, N), mk(S_RUN, 0, 8'h24, 8'h34, N, N),
                 mk(S_FLUSH, 0, N, N, 8'h34, N), mk(S_RUN, 0, 8'h54, N, N, 8'h34),
                 mk(S_RUN, 0, N, 8'h54, N, N), mk(S_RUN, 0, N, N, 8'h54, N),
                 mk(S_RUN, 0, N, N, N, 8'h54)};
        for (int i = 0; i < 7; i++) begin
            cycle(in_t[i], fv_v[i], br_v[i], 1'b0);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== 1'b1) $display("FAIL branch_pcwrite[%0d]: got %b want 1", i, bus.PCWrite); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL branch_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        idle(1);
    endtask

    task automatic test_hold();
        logic [7:0]  in_t [8];
        logic [34:0] ex_t [8];
        logic [7:0]  fv_v, hd_v, pc_v;
        logic [34:0] got, ex;
        in_t = '{8'h14, 8'h24, 8'h24, 8'h40, 8'h14, 8'h24, 8'h24, N};
        fv_v = 8'b0001_1111;
        hd_v = 8'b0010_0010;
        pc_v = 8'b1001_1101;
        ex_t = '{mk(S_RUN, 0, 8'h14, N, N, N), mk(S_RUN, 0, 8'h14, N, N, N),
                 mk(S_RUN, 0, 8'h24, 8'h14, N, N), mk(S_RUN, 0, 8'h40, 8'h24, 8'h14, N),
                 mk(S_RUN, 0, 8'h14, 8'h40, 8'h24, 8'h14), mk(S_RUN, 0, 8'h14, 8'h40, 8'h24, 8'h14),
                 mk(S_STALL, 0, 8'h14, N, 8'h40, 8'h24), mk(S_RUN, 0, N, 8'h14, N, 8'h40)};
        for (int i = 0; i < 8; i++) begin
            cycle(in_t[i], fv_v[i], 1'b0, hd_v[i]);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== pc_v[i]) $display("FAIL hold_pcwrite[%0d]: got %b want %b", i, bus.PCWrite, pc_v[i]); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL hold_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        idle(4);
    endtask

    task automatic test_branch_hold();
        logic [34:0] ex_t [4];
        logic [34:0] got, ex;
        ex_t = '{mk(S_RUN, 0, 8'h34, N, N, N), mk(S_RUN, 0, 8'h24, 8'h34, N, N),
                 mk(S_FLUSH, 0, N, N, 8'h34, N), mk(S_RUN, 0, N, N, N, 8'h34)};
        for (int i = 0; i < 4; i++) begin
            cycle((i == 0) ? 8'h34 : 8'h24, (i < 3), (i == 2), (i == 2));
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== 1'b1) $display("FAIL branch_hold_pcwrite[%0d]: got %b want 1", i, bus.PCWrite); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL branch_hold_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        idle(4);
    endtask

    task automatic test_stop_flush();
        logic [34:0] ex_t [3];
        logic [34:0] got, ex;
        ex_t = '{mk(S_RUN, 0, 8'h01, N, N, N), mk(S_FLUSH, 0, N, N, N, N), mk(S_RUN, 0, 8'h14, N, N, N)};
        for (int i = 0; i < 3; i++) begin
            cycle((i == 0) ? 8'h01 : 8'h14, 1'b1, (i == 1), 1'b0);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== 1'b1) $display("FAIL stop_flush_pcwrite[%0d]: got %b want 1", i, bus.PCWrite); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL stop_flush_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        idle(5); #1;
        got = snap();
        checks++; if (got !== mk(S_RUN, 0, N, N, N, N)) $display("FAIL stop_flush_no_halt: got %h want %h", got, mk(S_RUN, 0, N, N, N, N)); else passed++;
    endtask

    task automatic test_stop();
        logic [34:0] ex_t [5];
        logic [4:0]  pc_v;
        logic [34:0] got, ex;
        pc_v = 5'b00001;
        ex_t = '{mk(S_RUN, 0, 8'h01, N, N, N), mk(S_RUN, 0, N, 8'h01, N, N),
                 mk(S_RUN, 0, N, N, 8'h01, N), mk(S_RUN, 0, N, N, N, 8'h01),
                 mk(S_HALT, 1, N, N, N, 8'h01)};
        for (int i = 0; i < 5; i++) begin
            cycle((i == 0) ? 8'h01 : 8'h14, 1'b1, 1'b0, 1'b0);
            exp_q.push_back(ex_t[i]);
            #2;
            checks++; if (bus.PCWrite !== pc_v[i]) $display("FAIL stop_pcwrite[%0d]: got %b want %b", i, bus.PCWrite, pc_v[i]); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL stop_state[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_q.push_back(mk(S_HALT, 1, N, N, N, 8'h01));
            #2;
            checks++; if (bus.PCWrite !== 1'b0) $display("FAIL halt_pcwrite[%0d]: got %b want 0", i, bus.PCWrite); else passed++;
            @(posedge clock); #1;
            got = snap(); ex = exp_q.pop_front();
            checks++; if (got !== ex) $display("FAIL halt_frozen[%0d]: got %h want %h", i, got, ex); else passed++;
        end
        @(negedge clock);
        bus.FetchValid = 1'b0; bus.BranchTaken = 1'b0; bus.Hold = 1'b0;
        reset = 1'b0; #1;
        got = snap();
        checks++; if (got !== mk(S_RUN, 0, N, N, N, N)) $display("FAIL halt_reset_state: got %h want %h", got, mk(S_RUN, 0, N, N, N, N)); else passed++;
        @(negedge clock); reset = 1'b1;
        cycle(8'h14, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(S_RUN, 0, 8'h14, N, N, N));
        #2;
        checks++; if (bus.PCWrite !== 1'b1) $display("FAIL halt_reset_pcwrite: got %b want 1", bus.PCWrite); else passed++;
        @(posedge clock); #1;
        got = snap(); ex = exp_q.pop_front();
        checks++; if (got !== ex) $display("FAIL halt_reset_run: got %h want %h", got, ex); else passed++;
        idle(4);
    endtask

    task automatic test_reset_abort();
        logic [34:0] got, ex;
        cycle(8'h40, 1'b1, 1'b0, 1'b0); @(posedge clock);
        cycle(8'h14, 1'b1, 1'b0, 1'b0); @(posedge clock);
        cycle(8'h00, 1'b0, 1'b0, 1'b0); @(posedge clock); #1;
        checks++; if (bus.dbg_state !== STALL) $display("FAIL abort_enter_stall: got %0d want %0d", bus.dbg_state, S_STALL); else passed++;
        @(negedge clock); reset = 1'b0; #1;
        got = snap();
        checks++; if (got !== mk(S_RUN, 0, N, N, N, N)) $display("FAIL abort_stall_reset: got %h want %h", got, mk(S_RUN, 0, N, N, N, N)); else passed++;
        @(negedge clock); reset = 1'b1;
        cycle(8'h24, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(S_RUN, 0, 8'h24, N, N, N));
        #2;
        checks++; if (bus.PCWrite !== 1'b1) $display("FAIL abort_pcwrite: got %b want 1", bus.PCWrite); else passed++;
        @(posedge clock); #1;
        got = snap(); ex = exp_q.pop_front();
        checks++; if (got !== ex) $display("FAIL abort_no_bubble: got %h want %h", got, ex); else passed++;
        idle(4);
    endtask

`ifdef IR_PIPE_PERF_EN
    task automatic test_perf();
        @(negedge clock); reset = 1'b0;
        @(negedge clock); reset = 1'b1;
        test_load_use(8'h40, 8'h14, 1'b1);
        test_load_use(8'h80, 8'h24, 1'b1);
        test_load_use(8'hC0, 8'hC4, 1'b1);
        test_branch();
        #1;
        checks++; if (bus.BubbleCount !== 16'd4) $display("FAIL perf_bubbles: got %0d want 4", bus.BubbleCount); else passed++;
    endtask
`endif

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_straight();
        test_load_use(8'h40, 8'h14, 1'b1);
        test_load_use(8'h80, 8'h24, 1'b1);
        test_load_use(8'hC0, 8'hC4, 1'b1);
        test_load_use(8'h40, 8'h24, 1'b0);
        test_branch();
        test_hold();
        test_branch_hold();
        test_stop_flush();
        test_stop();
        test_reset_abort();
`ifdef IR_PIPE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ir_pipeline.md
IR_PIPELINE -- requirements
Module: ir_pipeline

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 IMemOut  in  8  instruction fetched at current PC.
REQ-004 FetchValid  in  1  IMemOut holds a valid instruction this cycle.
REQ-005 BranchTaken  in  1  execute stage resolved a taken branch for the instruction in IR3.
REQ-006 Hold  in  1  global freeze request from the memory side.
REQ-007 IR1Out, IR2Out, IR3Out, IR4Out  out  8 each  fetch, decode/RF, execute and writeback instruction registers.
REQ-008 PCWrite  out  1  PC may advance this cycle.
REQ-009 Halted  out  1  stop instruction has retired; pipeline frozen.

Function
REQ-010 NOP SHALL be 8'h0A (opcode 1010); load 0000, stop 0001, branches 1101/0101/1001.
REQ-011 States SHALL be RUN, STALL, FLUSH and HALT.
REQ-012 RUN shift: IR4<=IR3, IR3<=IR2, IR2<=IR1, IR1<=IMemOut, or NOP when FetchValid=0.
REQ-013 Load-use hazard: IR2 opcode 0000 and IR1 reads IR2[7:6] (IR1[7:6] or IR1[5:4]).
- On hazard: IR1 holds; IR2<=NOP; IR3/IR4 shift; PCWrite=0; state goes to STALL for exactly 1 cycle, then back to RUN.
REQ-014 BranchTaken=1: IR1<=NOP, IR2<=NOP; IR3/IR4 shift; PCWrite=1; state goes to FLUSH for 1 cycle, then RUN.
- No load-use detection in FLUSH.
REQ-015 Hold=1: all IRs retain their values; PCWrite=0; state unchanged.
REQ-016 Priority: HALT > BranchTaken > Hold > load-use > normal shift.
REQ-017 Stop in IR1: IR1 SHALL keep the stop opcode; IR1 reloads with NOP afterwards; PCWrite=0 until reset.
REQ-018 Stop reaching IR4: transition to HALT; Halted=1 registered next cycle; all IRs frozen; PCWrite=0; only reset exits HALT.
REQ-019 Stop flushed by BranchTaken SHALL NOT halt.
REQ-020 PCWrite SHALL be combinational from state and inputs; all IR outputs registered.

Reset
REQ-021 On reset low: IR1Out–IR4Out=8'h0A, state=RUN, Halted=0, PCWrite=1 from the first clock after release.
REQ-022 Reset asserted mid-STALL, FLUSH or HALT SHALL abort that state immediately, with no residual bubble.

Configuration
REQ-023 Macro IR_PIPE_PERF_EN.
- Defined: add output BubbleCount[15:0], counting cycles in STALL or FLUSH; saturates at 16'hFFFF; reset to 0; frozen in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-024 Package cpu_pkg SHALL hold opcode constants (LOAD, STORE, STOP, NOP, BPZ, BZ, BNZ), the NOP_INSTR word, and the state enum.
REQ-025 Sub-module ir_hazard_detect (combinational) SHALL contain the IR1/IR2 load-use comparison; all other logic stays in ir_pipeline.

Verification
REQ-026 Straight-line 0x14, 0x24, 0x34, 0x44 with FetchValid=1 -> IR4Out=0x14 on cycle 4; PCWrite=1 throughout.
REQ-027 Load 0x40 in IR2, IR1=0x14 (reads r1) -> 1 cycle PCWrite=0; IR2=0x0A next; IR1 holds 0x14; STALL for one cycle.
REQ-028 BranchTaken pulse with IR1=0x24, IR2=0x34 -> next cycle IR1=IR2=0x0A; IR3=0x34 dropped only after the flush rules apply; 2 bubbles reach IR4.
REQ-029 Stop 0x01 fetched -> PCWrite=0 from the next cycle; Halted=1 one cycle after 0x01 reaches IR4; IRs stable for 10 cycles.
REQ-030 BranchTaken and Hold together, plus reset asserted during HALT -> flush wins; after reset, IRs=0x0A, Halted=0.
REQ-031 With IR_PIPE_PERF_EN defined: 3 load-use stalls + 1 flush -> BubbleCount=4.
